fsk_modulator: RTL and testbench
================================

Name: fsk_modulator

Overview:
- Transmit-side counterpart of the team's period-counting FSK demodulator.
- Accepts bytes over a valid/ready handshake, frames each one (preamble, start, 8 data bits LSB-first, stop) and drives a phase-continuous square-wave FSK signal.
- The signal is sent to the ultrasonic transducer driver.
- Tone half-periods default to values that land bit 1 inside the demodulator's "1" window (2-period sum 161..185 clocks) and bit 0 outside it.

Parameters:
- HALF_PERIOD_ONE, 43: clocks per half cycle for a 1 bit (period 86).
- HALF_PERIOD_ZERO, 50: clocks per half cycle for a 0 bit (period 100).
- CYCLES_PER_BIT, 8: full tone periods per bit; must be at least 1.
- PREAMBLE_BITS, 2: alternating preamble bits before the start bit, beginning with 1; 0 means no preamble.

Ports:
- clk, input, 1: single system clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- tx_data, input, 8: byte to send; sampled only on accept.
- tx_valid, input, 1: tx_data is valid.
- tx_ready, output, 1: block can accept a byte.
- fsk_out, output, 1: FSK square wave.
- busy, output, 1: a frame is in progress.
- frame_done, output, 1: one-cycle pulse when the stop bit completes.

Behaviour:
- Reset, asynchronous: all outputs and state are cleared.
  - State IDLE; tx_ready=0, fsk_out=0, busy=0, frame_done=0; all counters 0.
  - tx_ready is registered and goes to 1 on the first clk edge after rst deasserts.
- Accept:
  - Occurs on an edge where tx_valid & tx_ready.
  - On that edge: tx_data is latched, tx_ready goes to 0, busy goes to 1, and the tone counters clear.
  - Next state is PREAMBLE, or START if PREAMBLE_BITS==0.
- State machine: IDLE -> PREAMBLE -> START -> DATA -> STOP -> IDLE.
  - PREAMBLE sends PREAMBLE_BITS bits alternating 1,0,1,...
  - START sends 0.
  - DATA sends 8 bits, LSB first; a 3-bit index wraps 7->0 and the state exits on wrap.
  - STOP sends 1.
- Tone generation:
  - The half-period counter counts 0..H-1, where H is the half period for the current bit. At H-1 it wraps and fsk_out toggles.
  - Each period starts low and ends low, so fsk_out is 0 at every bit boundary.
  - A period counter counts completed periods (two toggles). When it reaches CYCLES_PER_BIT, the bit ends and the next bit's H is selected on the same edge.
  - H changes only at bit boundaries, so there are no glitches or partial periods.
- Timing:
  - First rise of fsk_out occurs on the H-th edge after the accept edge.
  - Bit duration is exactly 2*H*CYCLES_PER_BIT clocks: 688 for a 1, 800 for a 0 at defaults.
- Frame end:
  - On the edge that completes STOP: frame_done=1 for one cycle, busy=0, state IDLE, tx_ready=1 on the same edge.
  - The earliest next accept is the following edge, so back-to-back frames have a 1-cycle gap with fsk_out=0.
- tx_valid while busy is ignored, and tx_data changes while busy have no effect.
- IDLE: fsk_out is held at 0 (no carrier), which lets the demodulator's timeout reset its accumulator.
- Reset mid-frame: the frame is aborted immediately, fsk_out=0, and the byte is dropped. No frame_done is issued.
- Counter widths: half counter is clog2(max(HALF_PERIOD_ONE, HALF_PERIOD_ZERO)) bits; period counter is clog2(CYCLES_PER_BIT+1) bits. No overflow is possible within the legal parameter range.

Decomposition:
- fsk_pkg holds:
  - the state enum (IDLE, PREAMBLE, START, DATA, STOP);
  - default half-period constants (43, 50) and default CYCLES_PER_BIT;
  - the demodulator window constants (160, 186), so both ends share one definition.
- Sub-module fsk_tone_gen:
  - inputs: clk, rst, restart, bit_val;
  - outputs: tone, bit_done pulse;
  - contains the half/period counters and the toggle.
- fsk_modulator holds the FSM, byte shift register and handshake.

Test Plan:
- Reset values: assert rst mid-clock -> fsk_out, tx_ready, busy, frame_done are 0 immediately; tx_ready=1 on the first edge after release.
- Single frame, default parameters:
  - Stimulus: send 0xA5.
  - Expected bit sequence: 1,0 | 0 | 1,0,1,0,0,1,0,1 | 1.
  - Expected durations: 688/800 clocks per bit; frame_done exactly 8928 clocks after the accept edge; first fsk_out rise 43 edges after accept.
- Back-to-back:
  - Stimulus: tx_valid held high with 0x00 then 0xFF.
  - Expected: second accept one edge after frame_done; fsk_out low for exactly that one cycle between frames.
- Busy protection: pulse tx_valid with 0x3C mid-frame -> not accepted; transmitted byte unchanged; tx_ready stays 0.
- Reset mid-frame: assert rst during DATA bit 3 -> fsk_out=0 at once; no frame_done; next byte after release transmits correctly.
- Loopback with the demodulator, default parameters:
  - Each 1 bit yields 2-period sums of 172, so data_out=1.
  - Each 0 bit yields sums of 200, so data_out=0.
  - Recovered bit stream matches the sent frame.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK modulator and the matching period-counting demodulator.
// Default tone timing and the demodulator "1" window are defined once here.
package fsk_pkg;

  localparam int unsigned DATA_W               = 8;
  localparam int unsigned HALF_PERIOD_ONE_DEF  = 43;
  localparam int unsigned HALF_PERIOD_ZERO_DEF = 50;
  localparam int unsigned CYCLES_PER_BIT_DEF   = 8;
  localparam int unsigned PREAMBLE_BITS_DEF    = 2;

  // Demodulator decides "1" when a 2-period sum lies strictly between these bounds
  localparam int unsigned DEMOD_ONE_SUM_LO = 160;
  localparam int unsigned DEMOD_ONE_SUM_HI = 186;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
    ST_STOP     = 3'd4
  } fsk_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold 0..v-1, never less than one
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fsk_tone_gen.sv
// Phase-continuous square-wave tone generator: half-period counter, period counter and toggle.
// Every bit spans CYCLES_PER_BIT whole periods that start and end low.
module fsk_tone_gen
  import fsk_pkg::*;
#(
  parameter int unsigned HALF_PERIOD_ONE  = HALF_PERIOD_ONE_DEF,
  parameter int unsigned HALF_PERIOD_ZERO = HALF_PERIOD_ZERO_DEF,
  parameter int unsigned CYCLES_PER_BIT   = CYCLES_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic bit_val,
  output logic tone,
  output logic bit_done
);

  localparam int unsigned HALF_W = clog2_min1(max_u(HALF_PERIOD_ONE, HALF_PERIOD_ZERO));
  localparam int unsigned PER_W  = clog2_min1(CYCLES_PER_BIT + 1);

  localparam logic [HALF_W-1:0] HALF_ONE_LAST  = HALF_W'(HALF_PERIOD_ONE - 1);
  localparam logic [HALF_W-1:0] HALF_ZERO_LAST = HALF_W'(HALF_PERIOD_ZERO - 1);
  localparam logic [PER_W-1:0]  PER_LAST       = PER_W'(CYCLES_PER_BIT - 1);

  logic [HALF_W-1:0] half_q, half_d;
  logic [PER_W-1:0]  period_q, period_d;
  logic              tone_q, tone_d;

  logic [HALF_W-1:0] half_last_c;
  logic              half_wrap_c;
  logic              period_end_c;
  logic              bit_done_c;

  assign half_last_c  = bit_val ? HALF_ONE_LAST : HALF_ZERO_LAST;
  assign half_wrap_c  = (half_q == half_last_c);
  // A period completes on the falling toggle
  assign period_end_c = half_wrap_c & tone_q;
  assign bit_done_c   = ~restart & period_end_c & (period_q == PER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q   <= '0;
      period_q <= '0;
      tone_q   <= 1'b0;
    end else begin
      half_q   <= half_d;
      period_q <= period_d;
      tone_q   <= tone_d;
    end
  end

  always_comb begin
    half_d   = half_q;
    period_d = period_q;
    tone_d   = tone_q;
    if (restart) begin
      half_d   = '0;
      period_d = '0;
      tone_d   = 1'b0;
    end else if (half_wrap_c) begin
      half_d = '0;
      tone_d = ~tone_q;
      if (period_end_c) begin
        period_d = (period_q == PER_LAST) ? '0 : period_q + PER_W'(1);
      end
    end else begin
      half_d = half_q + HALF_W'(1);
    end
  end

  assign tone     = tone_q;
  assign bit_done = bit_done_c;

endmodule

// File: rtl/fsk_modulator.sv
// Byte-framing FSK transmitter: valid/ready intake, preamble/start/data/stop sequencing,
// and tone generation for the ultrasonic transducer driver.
module fsk_modulator
  import fsk_pkg::*;
#(
  parameter int unsigned HALF_PERIOD_ONE  = HALF_PERIOD_ONE_DEF,
  parameter int unsigned HALF_PERIOD_ZERO = HALF_PERIOD_ZERO_DEF,
  parameter int unsigned CYCLES_PER_BIT   = CYCLES_PER_BIT_DEF,
  parameter int unsigned PREAMBLE_BITS    = PREAMBLE_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              fsk_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned PRE_W = clog2_min1(PREAMBLE_BITS);
  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);

  fsk_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic accept_c;
  logic restart_c;
  logic bit_val_c;
  logic bit_done_c;
  logic tone;

  assign accept_c  = tx_valid & tx_ready_q;
  // Tone counters stay cleared through IDLE, so the accept edge starts a fresh period
  assign restart_c = (state_q == ST_IDLE);

  // Value of the bit currently on air; preamble alternates starting with 1
  always_comb begin
    bit_val_c = 1'b0;
    unique case (state_q)
      ST_PREAMBLE: bit_val_c = ~pre_cnt_q[0];
      ST_START:    bit_val_c = 1'b0;
      ST_DATA:     bit_val_c = shreg_q[0];
      ST_STOP:     bit_val_c = 1'b1;
      default:     bit_val_c = 1'b0;
    endcase
  end

  fsk_tone_gen #(
    .HALF_PERIOD_ONE  (HALF_PERIOD_ONE),
    .HALF_PERIOD_ZERO (HALF_PERIOD_ZERO),
    .CYCLES_PER_BIT   (CYCLES_PER_BIT)
  ) u_tone (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart_c),
    .bit_val  (bit_val_c),
    .tone     (tone),
    .bit_done (bit_done_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_idx_q    <= '0;
      pre_cnt_q    <= '0;
      tx_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      pre_cnt_q    <= pre_cnt_d;
      tx_ready_q   <= tx_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_idx_d    = bit_idx_q;
    pre_cnt_d    = pre_cnt_q;
    tx_ready_d   = tx_ready_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_ready_d = 1'b1;
        if (accept_c) begin
          shreg_d    = tx_data;
          bit_idx_d  = '0;
          pre_cnt_d  = '0;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = (PREAMBLE_BITS == 0) ? ST_START : ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        if (bit_done_c) begin
          if (pre_cnt_q == PRE_LAST) begin
            state_d = ST_START;
          end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
          end
        end
      end
      ST_START: begin
        if (bit_done_c) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // LSB-first: shift right after each bit, leave once the index wraps
        if (bit_done_c) begin
          shreg_d   = {1'b0, shreg_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (bit_done_c) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          tx_ready_d   = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        tx_ready_d = 1'b0;
      end
    endcase
  end

  assign tx_ready   = tx_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign fsk_out    = tone;

endmodule

// File: tb/tb_fsk_modulator.sv
// Self-checking bench for fsk_modulator: table-driven frames plus back-to-back, busy and abort
// sequences; a negedge monitor measures tone periods and demodulates them against a scoreboard.
module tb_fsk_modulator;
  import fsk_pkg::*;

  localparam int H1  = 43;
  localparam int H0  = 50;
  localparam int CPB = 8;
  localparam int PRE = 2;

  typedef struct {
    logic [7:0] data;
    int         len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       fsk_out;
  logic       busy;
  logic       frame_done;

  int chk = 0;
  int err = 0;
  int cyc = 0;

  bit bit_q[$];
  int len_q[$];
  int periods[$];
  int acc_edge    = 0;
  int pstart      = 0;
  int frames_seen = 0;
  bit rise_pend   = 1'b0;
  bit prev_out    = 1'b0;
  bit exp_bit;
  int exp_h, bad, psum;
  bit rec_bit;

  vec_t tbl[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fsk_modulator dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fsk_out    (fsk_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] d, input int len);
    for (int p = 0; p < PRE; p++) bit_q.push_back((p % 2) == 0);
    bit_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
    bit_q.push_back(1'b1);
    len_q.push_back(len);
  endtask

  task automatic send(input logic [7:0] d, input int len);
    check("send_ready", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    push_frame(d, len);
    tick();
    tx_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_ready", tx_ready, 0);
    check("accept_fsk", fsk_out, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (frame_done !== 1'b1 && n < 12000) begin
      tick();
      n++;
    end
    if (frame_done !== 1'b1) check("frame_done_timeout", 0, 1);
  endtask

  // Monitor: period lengths, demodulator decision per bit, frame length and accept tracking
  always @(negedge clk) begin
    if (rst) begin
      periods.delete();
      bit_q.delete();
      len_q.delete();
      rise_pend = 1'b0;
      prev_out  = 1'b0;
    end else begin
      if (fsk_out && !prev_out && rise_pend) begin
        check("first_rise", cyc - acc_edge, H1);
        rise_pend = 1'b0;
      end
      if (!fsk_out && prev_out) begin
        periods.push_back(cyc - pstart);
        pstart = cyc;
        if (periods.size() == CPB) begin
          if (bit_q.size() == 0) begin
            check("unexpected_bit", 1, 0);
          end else begin
            exp_bit = bit_q.pop_front();
            exp_h   = exp_bit ? H1 : H0;
            bad     = 0;
            foreach (periods[k]) if (periods[k] != 2 * exp_h) bad++;
            check("bit_periods", bad, 0);
            psum    = periods[CPB-2] + periods[CPB-1];
            rec_bit = (psum > int'(DEMOD_ONE_SUM_LO)) && (psum < int'(DEMOD_ONE_SUM_HI));
            check("loopback_bit", rec_bit, exp_bit);
          end
          periods.delete();
        end
      end
      if (frame_done) begin
        frames_seen++;
        if (len_q.size() == 0) check("unexpected_done", 1, 0);
        else check("frame_len", cyc - acc_edge, len_q.pop_front());
        check("done_ready", tx_ready, 1);
        check("done_busy", busy, 0);
      end
      if (tx_valid && tx_ready) begin
        acc_edge  = cyc + 1;
        pstart    = cyc + 1;
        rise_pend = 1'b1;
        periods.delete();
      end
      prev_out = fsk_out;
    end
  end

  initial begin
    tbl[0] = '{data: 8'hA5, len: 8928};
    tbl[1] = '{data: 8'h81, len: 9152};
    tbl[2] = '{data: 8'h3C, len: 8928};

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fsk", fsk_out, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_edge", tx_ready, 0);
    tick();
    check("ready_after_release", tx_ready, 1);

    // Table-driven single frames; a 0x3C pulse mid-frame must be ignored
    for (int i = 0; i < 3; i++) begin
      send(tbl[i].data, tbl[i].len);
      if (i == 1) begin
        repeat (3000) tick();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick();
        check("busy_ignore_ready", tx_ready, 0);
        check("busy_ignore_busy", busy, 1);
        tx_valid = 1'b0;
      end
      wait_done();
      tick();
    end

    // Back-to-back with tx_valid held high; data change while busy must not leak
    check("b2b_ready", tx_ready, 1);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    push_frame(8'h00, 9376);
    tick();
    check("b2b_first_accept", busy, 1);
    tx_data = 8'hFF;
    wait_done();
    check("b2b_gap_low", fsk_out, 0);
    check("b2b_gap_ready", tx_ready, 1);
    push_frame(8'hFF, 8480);
    tick();
    check("b2b_second_accept_busy", busy, 1);
    check("b2b_second_accept_ready", tx_ready, 0);
    check("b2b_second_fsk", fsk_out, 0);
    tx_valid = 1'b0;
    wait_done();
    tick();

    // Abort during DATA bit 3 of 0xA5 while the tone is high
    send(8'hA5, 8928);
    repeat (4534) tick();
    check("abort_pre_high", fsk_out, 1);
    #3 rst = 1'b1;
    #1;
    check("abort_fsk", fsk_out, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", tx_ready, 0);
    check("abort_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("abort_ready_after", tx_ready, 1);
    send(tbl[0].data, tbl[0].len);
    wait_done();
    tick();

    check("frames_seen", frames_seen, 6);
    check("bits_left", bit_q.size(), 0);
    check("lens_left", len_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
